// File: rtl/mini_src_pkg.sv
// Shared ALU opcode constants, sequencer state encoding and opcode classification helpers.
package mini_src_pkg;

  localparam logic [4:0] OpAdd   = 5'b00011;
  localparam logic [4:0] OpSub   = 5'b00100;
  localparam logic [4:0] OpAnd   = 5'b00101;
  localparam logic [4:0] OpOr    = 5'b00110;
  localparam logic [4:0] OpXor   = 5'b00111;
  localparam logic [4:0] OpSll   = 5'b01000;
  localparam logic [4:0] OpSrl   = 5'b01001;
  localparam logic [4:0] OpSra   = 5'b01010;
  localparam logic [4:0] OpSlt   = 5'b01011;
  localparam logic [4:0] OpMul   = 5'b01111;
  localparam logic [4:0] OpDiv   = 5'b10000;
  localparam logic [4:0] OpMisc0 = 5'b10001;
  localparam logic [4:0] OpMisc1 = 5'b10010;
  localparam logic [4:0] OpClr   = 5'b11111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Mul and div produce a 64-bit result whose upper half is meaningful.
  function automatic logic is_wide(input logic [4:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic legal;
    unique case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt,
      OpMul, OpDiv, OpMisc0, OpMisc1, OpClr: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational classification of an ALU control code.
module alu_op_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] op,
  output logic       is_wide,
  output logic       is_legal
);

  assign is_wide  = mini_src_pkg::is_wide(op);
  assign is_legal = mini_src_pkg::is_legal(op);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request through an external combinational ALU and returns its result.
// Define ALU_OP_CHECK_EN to reject illegal opcodes with rsp_err instead of executing them.
module alu_op_sequencer
  import mini_src_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_control,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_wide,
  output logic        rsp_err
);

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [63:0] z_q, z_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wide_q, wide_d;
  logic        err_q, err_d;
  logic        req_wide, req_legal;

  alu_op_decode u_decode (
    .op       (req_op),
    .is_wide  (req_wide),
    .is_legal (req_legal)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    wide_d  = wide_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          y_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          cnt_d   = '0;
          wide_d  = req_wide;
          err_d   = 1'b0;
          state_d = StExec;
`ifdef ALU_OP_CHECK_EN
          // Illegal ops bypass the ALU entirely and report an error with a zero result.
          if (!req_legal) begin
            wide_d  = 1'b0;
            err_d   = 1'b1;
            z_d     = '0;
            state_d = StResp;
          end
`endif
        end
      end
      StExec: begin
        if (cnt_q == LastCnt) begin
          z_d     = alu_result;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      y_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      wide_q  <= wide_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign alu_y       = y_q;
  assign alu_b       = b_q;
  assign alu_control = (state_q == StExec) ? op_q : OpClr;
  assign rsp_lo      = z_q[31:0];
  assign rsp_hi      = wide_q ? z_q[63:32] : 32'h0;
  assign rsp_wide    = wide_q;

`ifdef ALU_OP_CHECK_EN
  assign rsp_err = err_q;
`else
  logic unused_check;
  assign unused_check = req_legal ^ err_q;
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench: one sequencer with SETTLE_CYCLES=1 and one with 4.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_y, alu_b;
  logic [4:0]  alu_control;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_wide, rsp_err;

  logic        req_valid2, req_ready2;
  logic [4:0]  req_op2;
  logic [31:0] req_a2, req_b2;
  logic [31:0] alu_y2, alu_b2;
  logic [4:0]  alu_control2;
  logic [63:0] alu_result2;
  logic        rsp_valid2, rsp_ready2;
  logic [31:0] rsp_lo2, rsp_hi2;
  logic        rsp_wide2, rsp_err2;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        saw_01100 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_control == 5'b01100) saw_01100 = 1'b1;

  // Reference ALU: add and mul are exact, everything else returns a tagged xor.
  always_comb begin
    case (alu_control)
      5'b00011: alu_result = {32'h0, alu_y + alu_b};
      5'b01111: alu_result = {32'h0, alu_y} * {32'h0, alu_b};
      default:  alu_result = {32'hdead0000, alu_y ^ alu_b};
    endcase
  end

  // Second instance sees a result that changes every cycle, exposing when it samples.
  assign alu_result2 = {32'h0, cyc};

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk         (clk),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_y       (alu_y),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_lo      (rsp_lo),
    .rsp_hi      (rsp_hi),
    .rsp_wide    (rsp_wide),
    .rsp_err     (rsp_err)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk         (clk),
    .clr         (clr),
    .req_valid   (req_valid2),
    .req_ready   (req_ready2),
    .req_op      (req_op2),
    .req_a       (req_a2),
    .req_b       (req_b2),
    .alu_y       (alu_y2),
    .alu_b       (alu_b2),
    .alu_control (alu_control2),
    .alu_result  (alu_result2),
    .rsp_valid   (rsp_valid2),
    .rsp_ready   (rsp_ready2),
    .rsp_lo      (rsp_lo2),
    .rsp_hi      (rsp_hi2),
    .rsp_wide    (rsp_wide2),
    .rsp_err     (rsp_err2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edges are counted with the accepting edge as edge 1.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_edges, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_wide, input logic exp_err,
                        input int hold);
    int          edges;
    logic [31:0] lo0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    edges     = 1;
    if (exp_edges > 1) check_eq("ctl_exec", alu_control, op);
    else               check_eq("ctl_skip", alu_control, 5'b11111);
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("rsp_edges", edges, exp_edges);
    check_eq("rsp_lo", rsp_lo, exp_lo);
    check_eq("rsp_hi", rsp_hi, exp_hi);
    check_eq("rsp_wide", rsp_wide, exp_wide);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("alu_y_held", alu_y, a);
    check_eq("ctl_resp", alu_control, 5'b11111);
    lo0 = rsp_lo;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_ready", req_ready, 1'b0);
      check_eq("hold_lo", rsp_lo, lo0);
      check_eq("hold_y", alu_y, a);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("done_valid", rsp_valid, 1'b0);
    check_eq("done_ready", req_ready, 1'b1);
  endtask

  initial begin
    int          vcount;
    int          edges;
    int unsigned c0;
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 5'b0;
    req_a      = 32'h0;
    req_b      = 32'h0;
    rsp_ready  = 1'b0;
    req_valid2 = 1'b0;
    req_op2    = 5'b0;
    req_a2     = 32'h0;
    req_b2     = 32'h0;
    rsp_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_lo", rsp_lo, 32'h0);
    check_eq("rst_rsp_hi", rsp_hi, 32'h0);
    check_eq("rst_rsp_wide", rsp_wide, 1'b0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_alu_y", alu_y, 32'h0);
    check_eq("rst_alu_b", alu_b, 32'h0);
    check_eq("rst_alu_ctl", alu_control, 5'b11111);
    check_eq("rst4_ready", req_ready2, 1'b1);

    // add, mul, a non-wide default op, div (wide) with backpressure
    run_op(5'b00011, 32'd5, 32'd7, 2, 32'd12, 32'h0, 1'b0, 1'b0, 0);
    run_op(5'b01111, 32'h10000, 32'h10000, 2, 32'h0, 32'h1, 1'b1, 1'b0, 0);
    run_op(5'b00100, 32'hff00ff00, 32'h0f0f0f0f, 2, 32'hf00ff00f, 32'h0, 1'b0, 1'b0, 0);
    run_op(5'b10000, 32'h1, 32'h3, 2, 32'h2, 32'hdead0000, 1'b1, 1'b0, 5);

`ifdef ALU_OP_CHECK_EN
    run_op(5'b01100, 32'h1234, 32'h00ff, 1, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    check_eq("illegal_never_driven", saw_01100, 1'b0);
`else
    run_op(5'b01100, 32'h1234, 32'h00ff, 2, 32'h12cb, 32'h0, 1'b0, 1'b0, 0);
    check_eq("illegal_forwarded", saw_01100, 1'b1);
`endif

    // clr while in EXEC aborts silently
    req_op    = 5'b00011;
    req_a     = 32'd9;
    req_b     = 32'd1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("abort_in_exec", alu_control, 5'b00011);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("abort_ready", req_ready, 1'b1);
    check_eq("abort_valid", rsp_valid, 1'b0);
    check_eq("abort_ctl", alu_control, 5'b11111);
    check_eq("abort_y", alu_y, 32'h0);
    vcount = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) vcount++;
    end
    check_eq("abort_no_rsp", vcount, 0);

    // SETTLE_CYCLES=4: result must come from the last EXEC cycle
    c0         = cyc;
    req_op2    = 5'b00011;
    req_a2     = 32'd3;
    req_b2     = 32'd4;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    edges      = 1;
    while (!rsp_valid2 && edges < 20) begin
      check_eq("s4_ctl", alu_control2, 5'b00011);
      @(posedge clk); #1;
      edges++;
    end
    check_eq("s4_edges", edges, 5);
    check_eq("s4_lo", rsp_lo2, c0 + 4);
    check_eq("s4_hi", rsp_hi2, 32'h0);
    rsp_ready2 = 1'b1;
    @(posedge clk); #1;
    rsp_ready2 = 1'b0;
    check_eq("s4_done", req_ready2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning EXEC-state cycles the combinational ALU is given before its result is captured (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid input 1 / req_ready output 1: request handshake; transfer when both high at a rising edge.
REQ-005 SHALL have ports req_op input 5 (ALU control code), req_a input 32 (Y operand), req_b input 32 (B operand).
REQ-006 SHALL have ports alu_y output 32, alu_b output 32, alu_control output 5: drive the ALU's y, b, control inputs.
REQ-007 SHALL have port alu_result input 64: ALU result.
REQ-008 SHALL have ports rsp_valid output 1 / rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_lo output 32, rsp_hi output 32, rsp_wide output 1 (mul/div result), rsp_err output 1 (unsupported op).

Function
REQ-010 SHALL implement states IDLE, EXEC, RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE; no acceptance in the cycle a response completes.
REQ-012 SHALL, on request transfer, register req_a into Y, req_b into B, req_op into OP, and enter EXEC with settle counter cleared.
REQ-013 SHALL drive alu_y=Y, alu_b=B at all times, and alu_control=OP in EXEC, else 5'b11111 (ALU clear code).
REQ-014 SHALL remain in EXEC for exactly SETTLE_CYCLES cycles, then capture alu_result into Z and enter RESP.
REQ-015 SHALL make rsp_valid rise SETTLE_CYCLES+1 edges after the accepting edge.
REQ-016 SHALL output rsp_lo=Z[31:0]; for OP 01111 (mul) or 10000 (div) rsp_hi=Z[63:32] and rsp_wide=1; otherwise rsp_hi=0, rsp_wide=0.
REQ-017 SHALL hold rsp_valid and all rsp_* fields stable in RESP until rsp_ready=1 at an edge, then return to IDLE.
REQ-018 SHALL ignore req_* inputs outside IDLE; Y, B, OP, Z change only on accept/capture.
REQ-019 SHALL treat legal ops as 00011,00100,00101,00110,00111,01000,01001,01010,01011,01111,10000,10001,10010,11111.

Reset
REQ-020 SHALL, with clr=1 at an edge, enter IDLE and zero Y, B, OP, Z, settle counter, rsp_err; clr overrides any handshake in the same cycle.
REQ-021 SHALL after reset present req_ready=1, rsp_valid=0, rsp_lo=rsp_hi=0, rsp_wide=0, rsp_err=0, alu_y=alu_b=0, alu_control=5'b11111.
REQ-022 SHALL on clr during EXEC or RESP abort the operation without emitting any response.

Configuration
REQ-023 SHALL honour macro ALU_OP_CHECK_EN: when defined, an accepted illegal op skips EXEC, enters RESP on the next edge with rsp_err=1, rsp_lo=rsp_hi=0, rsp_wide=0, and never drives it onto alu_control.
REQ-024 SHALL, with ALU_OP_CHECK_EN undefined, forward every op unchanged through EXEC and tie rsp_err=0.

Structure
REQ-025 SHALL take ALU opcode constants, the state enum and the is_wide/is_legal helpers from shared package mini_src_pkg.
REQ-026 SHALL keep opcode classification in one combinational sub-module alu_op_decode (outputs is_wide, is_legal).

Verification
REQ-027 SHALL cover add: a=5, b=7, op 00011, model returns 12 -> rsp_valid 2 edges after accept, rsp_lo=12, rsp_hi=0, rsp_wide=0.
REQ-028 SHALL cover mul: a=32'h10000, b=32'h10000, op 01111, model returns 64'h1_0000_0000 -> rsp_hi=1, rsp_lo=0, rsp_wide=1.
REQ-029 SHALL cover backpressure: rsp_ready low 5 cycles -> rsp fields stable, req_ready=0; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-030 SHALL cover clr during EXEC -> next cycle IDLE, rsp_valid=0, alu_control=5'b11111, no response ever emitted.
REQ-031 SHALL cover op 01100 -> with ALU_OP_CHECK_EN rsp_err=1 one edge after accept, alu_control never 01100; without it normal EXEC path, rsp_err=0.
REQ-032 SHALL cover SETTLE_CYCLES=4 -> rsp_valid 5 edges after accept, Z sampled from alu_result in the last EXEC cycle.
